// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit.
// States, opcodes, mux select codes and the control-word bundle.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXE  = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXE   = 4'd10,
    S_IWB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_LOGI  = 2'b11;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
  } ctrl_t;

  function automatic logic is_logi(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/multicycle_control_out_decode.sv
// Moore control-word decoder: state (and IR opcode) to datapath controls.
// Codes 12-15 decode to an all-zero word.
module mc_out_decode
  import mc_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] op,
  output ctrl_t      ctrl
);

  // one control word per state, everything else idle
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.memread = 1'b1;
        ctrl.irwrite = 1'b1;
        ctrl.pcwrite = 1'b1;
        ctrl.alusrcb = SRCB_4;
        ctrl.aluop   = ALU_ADD;
      end
      S_DECODE: begin
        ctrl.alusrcb = SRCB_IMMSH;
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_RTEXE: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_B;
        ctrl.aluop   = ALU_FUNCT;
      end
      S_RTWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca     = 1'b1;
        ctrl.alusrcb     = SRCB_B;
        ctrl.aluop       = ALU_SUB;
        ctrl.pcwritecond = 1'b1;
        ctrl.pcsource    = PCS_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pcwrite  = 1'b1;
        ctrl.pcsource = PCS_JUMP;
      end
      S_IEXE: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = is_logi(op) ? ALU_LOGI : ALU_ADD;
      end
      S_IWB: begin
        ctrl.regwrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS CPU.
// Define MC_MEMWAIT_EN to stall memory states on mem_ready.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         Op,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSource,
  output logic               ExtOp,
  output logic               Illegal,
  output logic [STATE_W-1:0] State
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       ext_q;
  logic       illegal_c;
  logic       ready;
  logic       fetch_go;
  ctrl_t      ctrl;

  logic is_r, is_mem, is_beq, is_j, is_imm;

  assign is_r   = (Op == OP_R);
  assign is_mem = (Op == OP_LW) || (Op == OP_SW);
  assign is_beq = (Op == OP_BEQ);
  assign is_j   = (Op == OP_J);
  assign is_imm = (Op == OP_ADDI) || is_logi(Op);

`ifdef MC_MEMWAIT_EN
  logic unused_in;
  assign unused_in = Zero;
  assign ready     = mem_ready;
`else
  logic unused_in;
  assign unused_in = Zero ^ mem_ready;
  assign ready     = 1'b1;
`endif

  // PC/IR loads in FETCH only once memory has answered
  assign fetch_go = ready || (state_q != S_FETCH);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // next-state dispatch and illegal-opcode flag
  always_comb begin
    state_d   = S_FETCH;
    illegal_c = 1'b0;
    case (state_q)
      S_FETCH:  state_d = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          is_r:    state_d = S_RTEXE;
          is_mem:  state_d = S_MEMADR;
          is_beq:  state_d = S_BRANCH;
          is_j:    state_d = S_JUMP;
          is_imm:  state_d = S_IEXE;
          default: illegal_c = 1'b1;
        endcase
      end
      S_MEMADR: state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = ready ? S_FETCH : S_MEMWR;
      S_RTEXE:  state_d = S_RTWB;
      S_RTWB:   state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_IEXE:   state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // extension mode latched per instruction at end of DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    ext_q <= 1'b1;
    else if (state_q == S_DECODE)  ext_q <= !is_logi(Op);
  end

  mc_out_decode u_dec (
    .state (state_q),
    .op    (Op),
    .ctrl  (ctrl)
  );

  // strobes are held low while reset is asserted
  assign PCWrite     = rst_n & ctrl.pcwrite & fetch_go;
  assign IRWrite     = rst_n & ctrl.irwrite & ready;
  assign PCWriteCond = rst_n & ctrl.pcwritecond;
  assign MemRead     = rst_n & ctrl.memread;
  assign MemWrite    = rst_n & ctrl.memwrite;
  assign RegWrite    = rst_n & ctrl.regwrite;
  assign Illegal     = rst_n & illegal_c;

  assign IorD     = ctrl.iord;
  assign MemtoReg = ctrl.memtoreg;
  assign RegDst   = ctrl.regdst;
  assign ALUSrcA  = ctrl.alusrca;
  assign ALUSrcB  = ctrl.alusrcb;
  assign ALUOp    = ctrl.aluop;
  assign PCSource = ctrl.pcsource;

  // branch offset always sign-extended during DECODE
  assign ExtOp = (state_q == S_DECODE) ? 1'b1 : ext_q;
  assign State = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control.
// Walks each instruction class through its state sequence.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] Op = 6'd0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, ExtOp, Illegal;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] State;

  int total = 0;
  int bad = 0;

  multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Zero(Zero),
    .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .ExtOp(ExtOp), .Illegal(Illegal),
    .State(State)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  int irw;
  int pcw;

  initial begin
    @(negedge clk);
    check("rst state", 32'(State), 0);
    check("rst pcw", 32'(PCWrite), 0);
    check("rst memrd", 32'(MemRead), 0);
    check("rst irw", 32'(IRWrite), 0);
    check("rst ext", 32'(ExtOp), 1);
    check("rst ill", 32'(Illegal), 0);
    rst_n = 1'b1;
    #1;
    check("f0 memrd", 32'(MemRead), 1);
    check("f0 irw", 32'(IRWrite), 1);
    check("f0 pcw", 32'(PCWrite), 1);
    check("f0 srcb", 32'(ALUSrcB), 1);
    check("f0 aluop", 32'(ALUOp), 0);

    // lw
    Op = 6'b100011;
    step();
    check("lw s1", 32'(State), 1);
    check("lw dec srcb", 32'(ALUSrcB), 3);
    check("lw dec ext", 32'(ExtOp), 1);
    check("lw dec ill", 32'(Illegal), 0);
    step();
    check("lw s2", 32'(State), 2);
    check("lw adr srca", 32'(ALUSrcA), 1);
    check("lw adr srcb", 32'(ALUSrcB), 2);
    check("lw adr rw", 32'(RegWrite), 0);
    step();
    check("lw s3", 32'(State), 3);
    check("lw rd memrd", 32'(MemRead), 1);
    check("lw rd iord", 32'(IorD), 1);
    check("lw rd rw", 32'(RegWrite), 0);
    step();
    check("lw s4", 32'(State), 4);
    check("lw wb rw", 32'(RegWrite), 1);
    check("lw wb m2r", 32'(MemtoReg), 1);
    check("lw wb dst", 32'(RegDst), 0);
    step();
    check("lw s0", 32'(State), 0);
    check("lw f rw", 32'(RegWrite), 0);

    // ori
    Op = 6'b001101;
    step();
    check("ori s1", 32'(State), 1);
    check("ori dec ext", 32'(ExtOp), 1);
    step();
    check("ori s10", 32'(State), 10);
    check("ori ex ext", 32'(ExtOp), 0);
    check("ori ex aluop", 32'(ALUOp), 3);
    check("ori ex srcb", 32'(ALUSrcB), 2);
    check("ori ex rw", 32'(RegWrite), 0);
    step();
    check("ori s11", 32'(State), 11);
    check("ori wb rw", 32'(RegWrite), 1);
    check("ori wb ext", 32'(ExtOp), 0);
    check("ori wb m2r", 32'(MemtoReg), 0);
    step();
    check("ori s0", 32'(State), 0);
    check("ori f ext", 32'(ExtOp), 0);

    // beq taken
    Op = 6'b000100;
    Zero = 1'b1;
    step();
    check("beq s1", 32'(State), 1);
    check("beq dec ext", 32'(ExtOp), 1);
    step();
    check("beq s8", 32'(State), 8);
    check("beq pwc", 32'(PCWriteCond), 1);
    check("beq pcs", 32'(PCSource), 1);
    check("beq aluop", 32'(ALUOp), 1);
    check("beq pcw", 32'(PCWrite), 0);
    step();
    check("beq s0", 32'(State), 0);
    Zero = 1'b0;

    // j
    Op = 6'b000010;
    step();
    check("j s1", 32'(State), 1);
    step();
    check("j s9", 32'(State), 9);
    check("j pcw", 32'(PCWrite), 1);
    check("j pcs", 32'(PCSource), 2);
    step();
    check("j s0", 32'(State), 0);

    // R-type
    Op = 6'b000000;
    step();
    step();
    check("r s6", 32'(State), 6);
    check("r aluop", 32'(ALUOp), 2);
    check("r srca", 32'(ALUSrcA), 1);
    check("r srcb", 32'(ALUSrcB), 0);
    step();
    check("r s7", 32'(State), 7);
    check("r rw", 32'(RegWrite), 1);
    check("r dst", 32'(RegDst), 1);
    step();
    check("r s0", 32'(State), 0);

    // sw
    Op = 6'b101011;
    step();
    step();
    check("sw s2", 32'(State), 2);
    step();
    check("sw s5", 32'(State), 5);
    check("sw mw", 32'(MemWrite), 1);
    check("sw iord", 32'(IorD), 1);
    check("sw memrd", 32'(MemRead), 0);
    step();
    check("sw s0", 32'(State), 0);

    // andi then addi
    Op = 6'b001100;
    step();
    step();
    check("andi s10", 32'(State), 10);
    check("andi ext", 32'(ExtOp), 0);
    check("andi aluop", 32'(ALUOp), 3);
    step();
    step();
    Op = 6'b001000;
    step();
    step();
    check("addi s10", 32'(State), 10);
    check("addi ext", 32'(ExtOp), 1);
    check("addi aluop", 32'(ALUOp), 0);
    step();
    step();
    check("addi s0", 32'(State), 0);

    // undefined opcode
    Op = 6'b111111;
    step();
    check("ill s1", 32'(State), 1);
    check("ill flag", 32'(Illegal), 1);
    check("ill mw", 32'(MemWrite), 0);
    check("ill rw", 32'(RegWrite), 0);
    check("ill pcw", 32'(PCWrite), 0);
    step();
    check("ill s0", 32'(State), 0);
    check("ill clr", 32'(Illegal), 0);

    // reset in MEMWB of lw
    Op = 6'b100011;
    step();
    step();
    step();
    step();
    check("rlw s4", 32'(State), 4);
    #2 rst_n = 1'b0;
    #1;
    check("rlw state", 32'(State), 0);
    check("rlw rw", 32'(RegWrite), 0);
    check("rlw ext", 32'(ExtOp), 1);
    check("rlw memrd", 32'(MemRead), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rlw rel", 32'(State), 0);
    check("rlw rel rd", 32'(MemRead), 1);

    // reset in IWB of ori restores ExtOp
    Op = 6'b001101;
    step();
    step();
    step();
    check("rori s11", 32'(State), 11);
    check("rori ext0", 32'(ExtOp), 0);
    #2 rst_n = 1'b0;
    #1;
    check("rori state", 32'(State), 0);
    check("rori ext", 32'(ExtOp), 1);
    check("rori rw", 32'(RegWrite), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

`ifdef MC_MEMWAIT_EN
    // FETCH stalls on memory, loads PC/IR once
    Op = 6'b000000;
    mem_ready = 1'b0;
    irw = 0;
    pcw = 0;
    for (int i = 0; i < 3; i++) begin
      check("wait state", 32'(State), 0);
      check("wait memrd", 32'(MemRead), 1);
      irw += int'(IRWrite);
      pcw += int'(PCWrite);
      step();
    end
    mem_ready = 1'b1;
    #1;
    irw += int'(IRWrite);
    pcw += int'(PCWrite);
    step();
    check("wait s1", 32'(State), 1);
    check("wait irw", 32'(irw), 1);
    check("wait pcw", 32'(pcw), 1);
    step();
    step();
    step();
    check("wait s0", 32'(State), 0);
`else
    // mem_ready is ignored without the wait option
    Op = 6'b000000;
    mem_ready = 1'b0;
    #1;
    check("nw irw", 32'(IRWrite), 1);
    check("nw pcw", 32'(PCWrite), 1);
    step();
    check("nw s1", 32'(State), 1);
    mem_ready = 1'b1;
    step();
    step();
    step();
    check("nw s0", 32'(State), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
